ps2_key_receiver: RTL
=====================

Name: ps2_key_receiver

Overview:
Upstream stage of the keypad parameter-entry FSM. It receives PS/2 device-to-host frames on the raw keyboard lines and decodes make, break and extended prefixes. It emits a one-cycle ps2_key_pressed strobe with a stable ps2_key_data byte, which the entry FSM consumes to build the volume, pitch and distortion values. It runs entirely in the system Clock domain and treats the PS/2 lines as asynchronous inputs.

Parameters:
FILTER_LEN, 8, system-clock cycles PS2_CLK must be stable before a level change is accepted (glitch filter).
TIMEOUT_CYCLES, 10000, maximum cycles between accepted PS2_CLK falling edges inside a frame (200 us at 50 MHz).
SUPPRESS_REPEAT, 1, when 1, typematic repeats of the currently held make code are not re-strobed.

Ports:
Clock  in  1  system clock, 50 MHz
Reset  in  1  synchronous, active-high reset
PS2_CLK  in  1  raw PS/2 clock, asynchronous
PS2_DAT  in  1  raw PS/2 data, asynchronous
ps2_key_data  out  8  last accepted scan code (make or break), held until the next accepted code
ps2_key_pressed  out  1  one-cycle pulse on an accepted make code
key_released  out  1  one-cycle pulse on an accepted break code (the byte after F0)
key_extended  out  1  qualifies ps2_key_data: code was preceded by E0; valid with either pulse
frame_error  out  1  one-cycle pulse on a parity error, stop-bit error or timeout

Behaviour:
- Interface: one clock (Clock). Reset is synchronous and active-high.
- Reset values: ps2_key_data=8'h00, key_extended=0, all pulses 0. FSM=IDLE. break_pending, ext_pending and held_code_valid are cleared. Asserting Reset mid-frame discards the partial frame with no error pulse.
- Input conditioning: each line passes through a 2-flop synchronizer.
  - PS2_CLK then goes through the FILTER_LEN stability filter.
  - A falling edge is a filtered 1->0 transition. PS2_DAT is sampled from its synchronized value in the same cycle as the edge.
- FSM states: IDLE, DATA, PARITY, STOP. A 3-bit bit counter runs in DATA.
  - IDLE: on an edge, if the sampled bit is 0, go to DATA and clear the counter. A start bit of 1 is ignored: stay in IDLE, no error.
  - DATA: shift the bit in LSB-first on each edge. After the 8th bit, go to PARITY.
  - PARITY: capture the bit, then go to STOP.
  - STOP: on the edge, check stop==1 and odd parity over data plus parity bit. Return to IDLE in all cases.
- Timeout: a counter is cleared on every edge and counts in any state except IDLE. When it reaches TIMEOUT_CYCLES, return to IDLE and pulse frame_error.
- Error handling: a bad parity or stop bit pulses frame_error and discards the byte. Both errors and timeouts clear break_pending and ext_pending. ps2_key_data is unchanged.
- Byte decode (on a valid frame):
  - 8'hE0: set ext_pending, no output.
  - 8'hF0: set break_pending, no output.
  - Other code with break_pending: ps2_key_data=code, key_extended=ext_pending, pulse key_released. If the code and extension match the held code, clear held_code_valid. Clear both pending flags.
  - Other code without break_pending: if SUPPRESS_REPEAT=1, held_code_valid is set and the code and extension match the held code, drop it silently. Otherwise update ps2_key_data and key_extended, pulse ps2_key_pressed, and record the held code. Clear ext_pending.
- Latency: the output pulses and the updated ps2_key_data appear exactly 1 cycle after the cycle in which the stop-bit edge is detected. ps2_key_data is already valid in the pulse cycle.
- Pulse exclusivity: at most one of ps2_key_pressed, key_released and frame_error is high in any cycle.
- Simultaneous events: Reset has priority over everything. An edge arriving in the same cycle the timeout expires is treated as timeout first, then the FSM is in IDLE for the next edge.

Decomposition:
- Package ps2_pkg: constants PS2_BREAK=8'hF0, PS2_EXT=8'hE0, PS2_FRAME_BITS=11, and the FSM state encoding (2-bit).
- Sub-module ps2_sync_filter: synchronizers, FILTER_LEN filter and falling-edge strobe. Outputs clk_fall and dat_sync.

Test Plan:
- Frame 0x16 with correct parity at a 60 us bit period -> one ps2_key_pressed pulse, ps2_key_data=0x16, key_extended=0, no frame_error.
- Sequence 16, F0 16 -> ps2_key_pressed for the first byte, then key_released with data 0x16. No pulse for the F0 byte.
- Frame 0x5A with a flipped parity bit -> frame_error pulse only. ps2_key_data keeps its prior value. A following good 0x5A frame -> pressed strobe.
- Five bits of a frame, then the lines idle -> frame_error exactly TIMEOUT_CYCLES after the last edge. A following good 0x26 frame is accepted.
- With SUPPRESS_REPEAT=1, 1E repeated three times -> one pressed pulse. F0 1E then 1E -> released pulse, then a second pressed pulse.
- E0 75 -> pressed with ps2_key_data=0x75 and key_extended=1. A 4-cycle low glitch on PS2_CLK in IDLE -> no state change, no pulses.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared constants, FSM state encoding and parity helper for the PS/2 key receiver.
package ps2_pkg;

  localparam logic [7:0] PS2_BREAK      = 8'hF0;
  localparam logic [7:0] PS2_EXT        = 8'hE0;
  localparam int         PS2_FRAME_BITS = 11;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } ps2_state_t;

  // PS/2 uses odd parity: data bits plus parity bit must hold an odd number of ones.
  function automatic logic odd_parity_ok(input logic [7:0] data, input logic parity);
    return ^{data, parity};
  endfunction

endpackage

// File: rtl/ps2_key_receiver_if.sv
// Bundles the raw PS/2 lines and the decoded key outputs of the receiver.
interface ps2_key_receiver_if;

  logic       PS2_CLK;
  logic       PS2_DAT;
  logic [7:0] ps2_key_data;
  logic       ps2_key_pressed;
  logic       key_released;
  logic       key_extended;
  logic       frame_error;

  modport master (
    output PS2_CLK,
    output PS2_DAT,
    input  ps2_key_data,
    input  ps2_key_pressed,
    input  key_released,
    input  key_extended,
    input  frame_error
  );

  modport slave (
    input  PS2_CLK,
    input  PS2_DAT,
    output ps2_key_data,
    output ps2_key_pressed,
    output key_released,
    output key_extended,
    output frame_error
  );

endinterface

// File: rtl/ps2_sync_filter.sv
// Synchronizes both PS/2 lines, glitch-filters the clock and strobes its falling edges.
module ps2_sync_filter #(
  parameter int FILTER_LEN = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic ps2_clk_raw,
  input  logic ps2_dat_raw,
  output logic clk_fall,
  output logic dat_sync
);

  localparam int CNT_W = $clog2(FILTER_LEN + 1);

  logic [1:0]       clk_meta_r;
  logic [1:0]       dat_meta_r;
  logic             clk_filt_r;
  logic [CNT_W-1:0] stab_cnt_r;
  logic             fall_r;
  logic             clk_sync_s;
  logic             accept_s;

  assign clk_sync_s = clk_meta_r[1];
  // A new level is accepted only after FILTER_LEN consecutive cycles of disagreement.
  assign accept_s   = (clk_sync_s != clk_filt_r) && (stab_cnt_r == CNT_W'(FILTER_LEN - 1));

  // Synchronizer chains, stability counter and registered falling-edge strobe.
  always_ff @(posedge clk) begin
    if (reset) begin
      clk_meta_r <= 2'b11;
      dat_meta_r <= 2'b11;
      clk_filt_r <= 1'b1;
      stab_cnt_r <= '0;
      fall_r     <= 1'b0;
    end else begin
      clk_meta_r <= {clk_meta_r[0], ps2_clk_raw};
      dat_meta_r <= {dat_meta_r[0], ps2_dat_raw};
      if (clk_sync_s == clk_filt_r) begin
        stab_cnt_r <= '0;
      end else if (accept_s) begin
        clk_filt_r <= clk_sync_s;
        stab_cnt_r <= '0;
      end else begin
        stab_cnt_r <= stab_cnt_r + CNT_W'(1);
      end
      fall_r <= accept_s & ~clk_sync_s;
    end
  end

  assign clk_fall = fall_r;
  assign dat_sync = dat_meta_r[1];

endmodule

// File: rtl/ps2_key_receiver.sv
// PS/2 device-to-host frame receiver with make/break/extended decode and typematic suppression.
module ps2_key_receiver
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN      = 8,
  parameter int TIMEOUT_CYCLES  = 10000,
  parameter int SUPPRESS_REPEAT = 1
) (
  input  logic               Clock,
  input  logic               Reset,
  ps2_key_receiver_if.slave  bus
);

  localparam int         TMO_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam int         DATA_BITS = PS2_FRAME_BITS - 3;
  localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

  logic             clk_fall_s;
  logic             dat_sync_s;
  logic             timeout_s;
  logic             held_match_s;

  ps2_state_t       state_r,      state_s;
  logic [2:0]       bit_cnt_r,    bit_cnt_s;
  logic [7:0]       shift_r,      shift_s;
  logic             parity_r,     parity_s;
  logic [TMO_W-1:0] tmo_cnt_r,    tmo_cnt_s;
  logic             break_pend_r, break_pend_s;
  logic             ext_pend_r,   ext_pend_s;
  logic             held_valid_r, held_valid_s;
  logic [7:0]       held_code_r,  held_code_s;
  logic             held_ext_r,   held_ext_s;
  logic [7:0]       key_data_r,   key_data_s;
  logic             key_ext_r,    key_ext_s;
  logic             pressed_r,    pressed_s;
  logic             released_r,   released_s;
  logic             frame_err_r,  frame_err_s;

  ps2_sync_filter #(.FILTER_LEN(FILTER_LEN)) u_sync_filter (
    .clk         (Clock),
    .reset       (Reset),
    .ps2_clk_raw (bus.PS2_CLK),
    .ps2_dat_raw (bus.PS2_DAT),
    .clk_fall    (clk_fall_s),
    .dat_sync    (dat_sync_s)
  );

  // Timeout wins over a coincident edge; the edge is then dropped with the FSM back in IDLE.
  assign timeout_s    = (state_r != ST_IDLE) && (tmo_cnt_r == TMO_W'(TIMEOUT_CYCLES - 1));
  assign held_match_s = (shift_r == held_code_r) && (ext_pend_r == held_ext_r);

  // Frame FSM, timeout counter and byte decoder next-state logic.
  always_comb begin
    state_s      = state_r;
    bit_cnt_s    = bit_cnt_r;
    shift_s      = shift_r;
    parity_s     = parity_r;
    tmo_cnt_s    = tmo_cnt_r;
    break_pend_s = break_pend_r;
    ext_pend_s   = ext_pend_r;
    held_valid_s = held_valid_r;
    held_code_s  = held_code_r;
    held_ext_s   = held_ext_r;
    key_data_s   = key_data_r;
    key_ext_s    = key_ext_r;
    pressed_s    = 1'b0;
    released_s   = 1'b0;
    frame_err_s  = 1'b0;

    if (timeout_s) begin
      state_s      = ST_IDLE;
      tmo_cnt_s    = '0;
      frame_err_s  = 1'b1;
      break_pend_s = 1'b0;
      ext_pend_s   = 1'b0;
    end else if (clk_fall_s) begin
      tmo_cnt_s = '0;
      case (state_r)
        ST_IDLE: begin
          if (!dat_sync_s) begin
            state_s   = ST_DATA;
            bit_cnt_s = 3'd0;
          end else begin
            state_s   = ST_IDLE;
          end
        end
        ST_DATA: begin
          shift_s = {dat_sync_s, shift_r[7:1]};
          if (bit_cnt_r == LAST_BIT) begin
            state_s = ST_PARITY;
          end else begin
            bit_cnt_s = bit_cnt_r + 3'd1;
          end
        end
        ST_PARITY: begin
          parity_s = dat_sync_s;
          state_s  = ST_STOP;
        end
        ST_STOP: begin
          state_s = ST_IDLE;
          if (!dat_sync_s || !odd_parity_ok(shift_r, parity_r)) begin
            frame_err_s  = 1'b1;
            break_pend_s = 1'b0;
            ext_pend_s   = 1'b0;
          end else if (shift_r == PS2_EXT) begin
            ext_pend_s = 1'b1;
          end else if (shift_r == PS2_BREAK) begin
            break_pend_s = 1'b1;
          end else if (break_pend_r) begin
            key_data_s   = shift_r;
            key_ext_s    = ext_pend_r;
            released_s   = 1'b1;
            break_pend_s = 1'b0;
            ext_pend_s   = 1'b0;
            if (held_match_s) begin
              held_valid_s = 1'b0;
            end else begin
              held_valid_s = held_valid_r;
            end
          end else if ((SUPPRESS_REPEAT != 0) && held_valid_r && held_match_s) begin
            // Typematic repeat of the key still held down: swallow it.
            ext_pend_s = 1'b0;
          end else begin
            key_data_s   = shift_r;
            key_ext_s    = ext_pend_r;
            pressed_s    = 1'b1;
            held_valid_s = 1'b1;
            held_code_s  = shift_r;
            held_ext_s   = ext_pend_r;
            ext_pend_s   = 1'b0;
          end
        end
        default: begin
          state_s = ST_IDLE;
        end
      endcase
    end else if (state_r != ST_IDLE) begin
      tmo_cnt_s = tmo_cnt_r + TMO_W'(1);
    end else begin
      tmo_cnt_s = '0;
    end
  end

  // State and output registers; reset discards any partial frame silently.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_r      <= ST_IDLE;
      bit_cnt_r    <= 3'd0;
      shift_r      <= 8'h00;
      parity_r     <= 1'b0;
      tmo_cnt_r    <= '0;
      break_pend_r <= 1'b0;
      ext_pend_r   <= 1'b0;
      held_valid_r <= 1'b0;
      held_code_r  <= 8'h00;
      held_ext_r   <= 1'b0;
      key_data_r   <= 8'h00;
      key_ext_r    <= 1'b0;
      pressed_r    <= 1'b0;
      released_r   <= 1'b0;
      frame_err_r  <= 1'b0;
    end else begin
      state_r      <= state_s;
      bit_cnt_r    <= bit_cnt_s;
      shift_r      <= shift_s;
      parity_r     <= parity_s;
      tmo_cnt_r    <= tmo_cnt_s;
      break_pend_r <= break_pend_s;
      ext_pend_r   <= ext_pend_s;
      held_valid_r <= held_valid_s;
      held_code_r  <= held_code_s;
      held_ext_r   <= held_ext_s;
      key_data_r   <= key_data_s;
      key_ext_r    <= key_ext_s;
      pressed_r    <= pressed_s;
      released_r   <= released_s;
      frame_err_r  <= frame_err_s;
    end
  end

  assign bus.ps2_key_data    = key_data_r;
  assign bus.key_extended    = key_ext_r;
  assign bus.ps2_key_pressed = pressed_r;
  assign bus.key_released    = released_r;
  assign bus.frame_error     = frame_err_r;

endmodule
